// File: rtl/memoria_pkg.sv
// +----------------------------------------------------------------------------+
// | memoria_pkg                                                                 |
// | Shared sizes, reset image function and empty-word constant for the         |
// | instruction memory.                                                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package memoria_pkg;

  localparam int MEM_DATA_WIDTH = 16;
  localparam int MEM_ADDR_WIDTH = 4;
  localparam int MEM_DEPTH      = 16;

  // Same value the fetch FIFO uses for an empty slot.
  localparam logic [15:0] ZERO_WORD = 16'h0000;

  function automatic logic [15:0] DEFAULT_PROGRAM(input logic [31:0] index);
    return {4'h0, index[3:0], 4'h0, index[3:0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/memoria_imagem_padrao.sv
// +----------------------------------------------------------------------------+
// | memoria_imagem_padrao                                                      |
// | Combinational ROM returning the default program word for one index.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module memoria_imagem_padrao
  import memoria_pkg::*;
#(
  parameter int DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] index,
  output logic [DATA_WIDTH-1:0] word
);

  logic [31:0] w_index_ext;

  assign w_index_ext = 32'(index);
  assign word        = DATA_WIDTH'(DEFAULT_PROGRAM(w_index_ext));

endmodule

`default_nettype wire

// File: rtl/memoria_de_instrucoes.sv
// +----------------------------------------------------------------------------+
// | memoria_de_instrucoes                                                      |
// | Single-port instruction memory, synchronous read with registered Q,        |
// | reset reloads the default program. MEMORIA_WRITE_FIRST_EN selects          |
// | write-first forwarding instead of read-first.                              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module memoria_de_instrucoes
  import memoria_pkg::*;
#(
  parameter int DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int DEPTH      = MEM_DEPTH
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Wren,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] Din,
  output logic [DATA_WIDTH-1:0] Q
);

  localparam int                  c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] c_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_q;
  logic [DATA_WIDTH-1:0] w_image [DEPTH];
  logic                  w_in_range;
  logic [c_IDX_W-1:0]    w_idx;

  // Addresses at or beyond DEPTH neither read nor write storage.
  assign w_in_range = ({1'b0, Address} < c_DEPTH);
  assign w_idx      = c_IDX_W'(Address);

  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_reset_image
      memoria_imagem_padrao #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
      ) u_imagem (
        .index (ADDR_WIDTH'(g)),
        .word  (w_image[g])
      );
    end
  endgenerate

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= w_image[i];
      end
    end else if (Wren && w_in_range) begin
      r_mem[w_idx] <= Din;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_q <= DATA_WIDTH'(ZERO_WORD);
    end else if (!w_in_range) begin
      r_q <= DATA_WIDTH'(ZERO_WORD);
    end else begin
`ifdef MEMORIA_WRITE_FIRST_EN
      r_q <= Wren ? Din : r_mem[w_idx];
`else
      r_q <= r_mem[w_idx];
`endif
    end
  end

  assign Q = r_q;

endmodule

`default_nettype wire

// File: tb/tb_memoria_de_instrucoes.sv
// +----------------------------------------------------------------------------+
// | tb_memoria_de_instrucoes                                                   |
// | Scoreboard bench driving a 16-word and a 12-word instance in lockstep.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_memoria_de_instrucoes;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Wren  = 1'b0;
  logic [3:0]  Address = 4'd0;
  logic [15:0] Din = 16'h0000;
  logic [15:0] q16;
  logic [15:0] q12;

  logic [15:0] m16 [16];
  logic [15:0] m12 [12];
  logic [15:0] exp16_q [$];
  logic [15:0] exp12_q [$];

  int n_checks = 0;
  int n_passed = 0;

  always #5 Clock = ~Clock;

  memoria_de_instrucoes #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .DEPTH(16)) u_dut16 (
    .Clock   (Clock),
    .Reset   (Reset),
    .Wren    (Wren),
    .Address (Address),
    .Din     (Din),
    .Q       (q16)
  );

  memoria_de_instrucoes #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .DEPTH(12)) u_dut12 (
    .Clock   (Clock),
    .Reset   (Reset),
    .Wren    (Wren),
    .Address (Address),
    .Din     (Din),
    .Q       (q12)
  );

  function automatic logic [15:0] image_word(input int i);
    logic [3:0] n;
    n = 4'(i);
    return {4'h0, n, 4'h0, n};
  endfunction

  task automatic check_value(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    n_checks++;
    if (observed === expected) n_passed++;
    else $display("FAIL %s: got %h, expected %h", tag, observed, expected);
  endtask

  // Drive one cycle at the falling edge, predict Q, then compare just after the rising edge.
  task automatic step(input logic rst, input logic wr, input logic [3:0] a,
                      input logic [15:0] d, input string tag);
    logic [15:0] e16;
    logic [15:0] e12;
    @(negedge Clock);
    Reset = rst; Wren = wr; Address = a; Din = d;
    if (rst) begin
      e16 = 16'h0000;
      e12 = 16'h0000;
      for (int i = 0; i < 16; i++) m16[i] = image_word(i);
      for (int i = 0; i < 12; i++) m12[i] = image_word(i);
    end else begin
`ifdef MEMORIA_WRITE_FIRST_EN
      e16 = wr ? d : m16[a];
      e12 = (int'(a) < 12) ? (wr ? d : m12[a]) : 16'h0000;
`else
      e16 = m16[a];
      e12 = (int'(a) < 12) ? m12[a] : 16'h0000;
`endif
      if (wr) begin
        m16[a] = d;
        if (int'(a) < 12) m12[a] = d;
      end
    end
    exp16_q.push_back(e16);
    exp12_q.push_back(e12);
    @(posedge Clock);
    #1;
    check_value({tag, "/d16"}, q16, exp16_q.pop_front());
    check_value({tag, "/d12"}, q12, exp12_q.pop_front());
  endtask

  initial begin
    step(1'b1, 1'b0, 4'd0, 16'h0000, "reset0");
    step(1'b1, 1'b0, 4'd0, 16'h0000, "reset1");

    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 4'(i), 16'h0000, "sweep");

    step(1'b0, 1'b1, 4'd7, 16'hBEEF, "write7");
`ifdef MEMORIA_WRITE_FIRST_EN
    check_value("write7_lit", q16, 16'hBEEF);
`else
    check_value("write7_lit", q16, 16'h0707);
`endif
    step(1'b0, 1'b0, 4'd7, 16'h0000, "read7");
    check_value("read7_lit", q16, 16'hBEEF);

    step(1'b0, 1'b0, 4'd2, 16'hFFFF, "nowren2");
    step(1'b0, 1'b0, 4'd2, 16'h0000, "read2");
    check_value("read2_lit", q16, 16'h0202);

    step(1'b0, 1'b1, 4'd9, 16'h1234, "write9");
    step(1'b0, 1'b0, 4'd9, 16'h0000, "read9a");
    step(1'b1, 1'b1, 4'd9, 16'hAAAA, "resetwr9");
    step(1'b0, 1'b0, 4'd9, 16'h0000, "read9b");
    check_value("read9b_lit", q16, 16'h0909);

    step(1'b0, 1'b0, 4'd15, 16'h0000, "wrap15");
    check_value("wrap15_lit", q16, 16'h0F0F);
    step(1'b0, 1'b0, 4'd0, 16'h0000, "wrap0");
    check_value("wrap0_lit", q16, 16'h0000);

    step(1'b0, 1'b0, 4'd13, 16'h0000, "oor13");
    check_value("oor13_lit", q12, 16'h0000);
    step(1'b0, 1'b1, 4'd13, 16'h5555, "wroor13");
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 4'(i), 16'h0000, "postoor");

    for (int k = 0; k < 60; k++) begin
      step(($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1,
           4'($urandom_range(0, 15)), 16'($urandom), "random");
    end

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
